// File: rtl/useq_pkg.sv
// useq_pkg: shared widths, COND/state encodings and PSR flag positions for the micro-sequencer.
package useq_pkg;
    localparam int JUMP_ADDR_BUS_WIDTH = 11;
    localparam int COND_BUS_WIDTH = 3;
    localparam int IR_BUS_WIDTH = 32;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;
    typedef enum logic [2:0] {
        COND_NEXT   = 3'd0,
        COND_N      = 3'd1,
        COND_Z      = 3'd2,
        COND_V      = 3'd3,
        COND_C      = 3'd4,
        COND_IR13   = 3'd5,
        COND_JMP    = 3'd6,
        COND_DECODE = 3'd7
    } cond_e;
    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2,
        S_TRAP    = 2'd3
    } state_e;
endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: microinstruction fields, datapath status and sequencer outputs.
interface micro_sequencer_if;
    import useq_pkg::*;
    logic [COND_BUS_WIDTH-1:0]      uSeq_COND_IN;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] uSeq_JUMP_ADDR_IN;
    logic                           uSeq_RD_IN;
    logic                           uSeq_WR_IN;
    logic [3:0]                     uSeq_Flags_IN;
    logic [IR_BUS_WIDTH-1:0]        uSeq_IR_IN;
    logic                           uSeq_MemAck_IN;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] uSeq_CSAddr_OUT;
    logic                           uSeq_MemReq_OUT;
    logic                           uSeq_DataPathEn_OUT;
    logic                           uSeq_MemErr_OUT;
    logic [1:0]                     uSeq_State_OUT;
    modport master (
        output uSeq_COND_IN, uSeq_JUMP_ADDR_IN, uSeq_RD_IN, uSeq_WR_IN, uSeq_Flags_IN, uSeq_IR_IN, uSeq_MemAck_IN,
        input  uSeq_CSAddr_OUT, uSeq_MemReq_OUT, uSeq_DataPathEn_OUT, uSeq_MemErr_OUT, uSeq_State_OUT
    );
    modport slave (
        input  uSeq_COND_IN, uSeq_JUMP_ADDR_IN, uSeq_RD_IN, uSeq_WR_IN, uSeq_Flags_IN, uSeq_IR_IN, uSeq_MemAck_IN,
        output uSeq_CSAddr_OUT, uSeq_MemReq_OUT, uSeq_DataPathEn_OUT, uSeq_MemErr_OUT, uSeq_State_OUT
    );
endinterface

// File: rtl/useq_next_addr.sv
// useq_next_addr: combinational next-address select from COND, flags and macro IR.
module useq_next_addr
    import useq_pkg::*;
(
    input  logic [COND_BUS_WIDTH-1:0]      cond_i,
    input  logic [JUMP_ADDR_BUS_WIDTH-1:0] jump_i,
    input  logic [JUMP_ADDR_BUS_WIDTH-1:0] upc_i,
    input  logic [3:0]                     flags_i,
    input  logic [IR_BUS_WIDTH-1:0]        ir_i,
    output logic [JUMP_ADDR_BUS_WIDTH-1:0] na_o
);
    logic take;
    logic unused_ir;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] inc;
    assign inc = upc_i + 11'd1;
    assign unused_ir = ^{ir_i[29:25], ir_i[18:14], ir_i[12:0]};
    always_comb begin
        take = 1'b0;
        case (cond_e'(cond_i))
            COND_N:    take = flags_i[FLAG_N];
            COND_Z:    take = flags_i[FLAG_Z];
            COND_V:    take = flags_i[FLAG_V];
            COND_C:    take = flags_i[FLAG_C];
            COND_IR13: take = ir_i[13];
            COND_JMP:  take = 1'b1;
            default:   take = 1'b0;
        endcase
        // decode vectors into the upper half of the store, four words per opcode
        na_o = (cond_e'(cond_i) == COND_DECODE) ? {1'b1, ir_i[31:30], ir_i[24:19], 2'b00}
             : take ? jump_i : inc;
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store address register with memory-stall and timeout-trap FSM.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_WIDTH = 5,
    parameter logic [JUMP_ADDR_BUS_WIDTH-1:0] TRAP_ADDR = 11'h7FF
) (
    input logic uSeq_CLOCK_50,
    input logic SC_uSeq_Reset_InHigh,
    micro_sequencer_if.slave bus
);
    state_e state_q, state_d;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] addr_q, addr_d, na;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic err_q, err_d, mem, mem_req, dp_en;
    assign mem = bus.uSeq_RD_IN | bus.uSeq_WR_IN;
    useq_next_addr u_na (
        .cond_i (bus.uSeq_COND_IN),
        .jump_i (bus.uSeq_JUMP_ADDR_IN),
        .upc_i  (addr_q),
        .flags_i(bus.uSeq_Flags_IN),
        .ir_i   (bus.uSeq_IR_IN),
        .na_o   (na)
    );
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mem_req = 1'b0;
        dp_en   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN: begin
                mem_req = mem;
                if (!mem || bus.uSeq_MemAck_IN) begin
                    addr_d = na;
                    dp_en  = 1'b1;
                end else begin
                    cnt_d   = TIMEOUT_WIDTH'(1);
                    state_d = S_MEMWAIT;
                end
            end
            S_MEMWAIT: begin
                mem_req = 1'b1;
                // a late ack on the timeout edge still completes the access
                if (bus.uSeq_MemAck_IN) begin
                    dp_en   = 1'b1;
                    addr_d  = na;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (cnt_q == TIMEOUT_WIDTH'(MEM_TIMEOUT)) begin
                    addr_d  = TRAP_ADDR;
                    err_d   = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TRAP: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
        endcase
    end
    always_ff @(posedge uSeq_CLOCK_50) begin
        if (SC_uSeq_Reset_InHigh) begin
            state_q <= S_RESET;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign bus.uSeq_CSAddr_OUT     = addr_q;
    assign bus.uSeq_MemReq_OUT     = mem_req;
    assign bus.uSeq_DataPathEn_OUT = dp_en;
    assign bus.uSeq_MemErr_OUT     = err_q;
    assign bus.uSeq_State_OUT      = state_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: table vectors, hand-written stall/timeout/reset sequences and random traffic vs a reference model.
module tb_micro_sequencer;
    typedef struct {
        logic        rst;
        logic [2:0]  cond;
        logic [10:0] jump;
        logic        rd;
        logic        wr;
        logic [3:0]  flags;
        logic [31:0] ir;
        logic        ack;
    } in_t;
    typedef struct {
        in_t         i;
        logic [10:0] addr;
        logic [1:0]  st;
        logic        req;
        logic        dpe;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    micro_sequencer_if bus();
    micro_sequencer dut (
        .uSeq_CLOCK_50       (clk),
        .SC_uSeq_Reset_InHigh(rst),
        .bus                 (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int m_st, m_addr, m_wait;
    bit m_err;
    logic s_req, s_dpe;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic r, input logic [2:0] c, input logic [10:0] j, input logic rd,
                               input logic wr, input logic [3:0] f, input logic [31:0] ir, input logic a);
        in_t v;
        v.rst = r; v.cond = c; v.jump = j; v.rd = rd; v.wr = wr; v.flags = f; v.ir = ir; v.ack = a;
        return v;
    endfunction

    // next address straight from the COND table; flags are {n,z,v,c}
    function automatic int na_ref(input in_t v, input int upc);
        int inc;
        inc = (upc + 1) % 2048;
        case (v.cond)
            3'd0: return inc;
            3'd1, 3'd2, 3'd3, 3'd4: return v.flags[4 - int'(v.cond)] ? int'(v.jump) : inc;
            3'd5: return v.ir[13] ? int'(v.jump) : inc;
            3'd6: return int'(v.jump);
            default: return 1024 + int'(v.ir[31:30]) * 256 + int'(v.ir[24:19]) * 4;
        endcase
    endfunction

    task automatic cycle(input in_t v);
        logic mem, exp_req, exp_dpe;
        int na;
        @(negedge clk);
        rst = v.rst;
        bus.uSeq_COND_IN = v.cond;
        bus.uSeq_JUMP_ADDR_IN = v.jump;
        bus.uSeq_RD_IN = v.rd;
        bus.uSeq_WR_IN = v.wr;
        bus.uSeq_Flags_IN = v.flags;
        bus.uSeq_IR_IN = v.ir;
        bus.uSeq_MemAck_IN = v.ack;
        #1;
        mem = v.rd | v.wr;
        exp_req = (m_st == 1) ? mem : (m_st == 2);
        exp_dpe = (m_st == 1 && (!mem || v.ack)) || (m_st == 2 && v.ack);
        s_req = bus.uSeq_MemReq_OUT;
        s_dpe = bus.uSeq_DataPathEn_OUT;
        check("model_memreq", s_req, exp_req);
        check("model_dpen", s_dpe, exp_dpe);
        na = na_ref(v, m_addr);
        @(posedge clk);
        #1;
        if (v.rst) begin
            m_st = 0; m_addr = 0; m_wait = 0; m_err = 0;
        end else if (m_st == 0 || m_st == 3) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (!mem || v.ack) m_addr = na;
            else begin m_wait = 1; m_st = 2; end
        end else if (v.ack) begin
            m_addr = na; m_st = 1; m_wait = 0;
        end else if (m_wait == 16) begin
            m_addr = 'h7FF; m_err = 1; m_st = 3;
        end else begin
            m_wait++;
        end
        check("model_csaddr", bus.uSeq_CSAddr_OUT, m_addr);
        check("model_state", bus.uSeq_State_OUT, m_st);
        check("model_memerr", bus.uSeq_MemErr_OUT, m_err);
    endtask

    task automatic add(input in_t i, input logic [10:0] a, input logic [1:0] s, input logic q, input logic d);
        vec_t t;
        t.i = i; t.addr = a; t.st = s; t.req = q; t.dpe = d; t.err = 1'b0;
        tbl.push_back(t);
    endtask

    initial begin
        in_t v;
        int thr;
        rst = 1'b1;
        bus.uSeq_COND_IN = '0; bus.uSeq_JUMP_ADDR_IN = '0; bus.uSeq_RD_IN = 0; bus.uSeq_WR_IN = 0;
        bus.uSeq_Flags_IN = '0; bus.uSeq_IR_IN = '0; bus.uSeq_MemAck_IN = 0;
        repeat (2) @(posedge clk);
        #1;
        m_st = 0; m_addr = 0; m_wait = 0; m_err = 0;

        add(mk(1, 0, 0, 0, 0, 0, 0, 0), 11'h000, 0, 0, 0);
        add(mk(0, 0, 0, 0, 0, 0, 0, 0), 11'h000, 1, 0, 0);
        add(mk(0, 0, 0, 0, 0, 0, 0, 0), 11'h001, 1, 0, 1);
        add(mk(0, 0, 0, 0, 0, 0, 0, 0), 11'h002, 1, 0, 1);
        add(mk(0, 0, 0, 0, 0, 0, 0, 0), 11'h003, 1, 0, 1);
        add(mk(0, 6, 11'h010, 0, 0, 4'b0000, 0, 0), 11'h010, 1, 0, 1);
        add(mk(0, 2, 11'h100, 0, 0, 4'b0100, 0, 0), 11'h100, 1, 0, 1);
        add(mk(0, 6, 11'h010, 0, 0, 4'b0000, 0, 0), 11'h010, 1, 0, 1);
        add(mk(0, 2, 11'h100, 0, 0, 4'b1011, 0, 0), 11'h011, 1, 0, 1);
        add(mk(0, 6, 11'h100, 0, 0, 4'b0000, 0, 0), 11'h100, 1, 0, 1);
        add(mk(0, 6, 11'h7FF, 0, 0, 4'b1111, 0, 0), 11'h7FF, 1, 0, 1);
        add(mk(0, 0, 11'h123, 0, 0, 4'b1111, 0, 0), 11'h000, 1, 0, 1);
        add(mk(0, 7, 11'h123, 0, 0, 0, 32'h8080_0000, 0), 11'h640, 1, 0, 1);
        add(mk(0, 1, 11'h0AA, 0, 0, 4'b1000, 0, 0), 11'h0AA, 1, 0, 1);
        add(mk(0, 3, 11'h155, 0, 0, 4'b0010, 0, 0), 11'h155, 1, 0, 1);
        add(mk(0, 4, 11'h200, 0, 0, 4'b1110, 0, 0), 11'h156, 1, 0, 1);
        add(mk(0, 5, 11'h033, 0, 0, 0, 32'h0000_2000, 0), 11'h033, 1, 0, 1);
        foreach (tbl[i]) begin
            cycle(tbl[i].i);
            check($sformatf("tbl%0d_memreq", i), s_req, tbl[i].req);
            check($sformatf("tbl%0d_dpen", i), s_dpe, tbl[i].dpe);
            check($sformatf("tbl%0d_csaddr", i), bus.uSeq_CSAddr_OUT, tbl[i].addr);
            check($sformatf("tbl%0d_state", i), bus.uSeq_State_OUT, tbl[i].st);
            check($sformatf("tbl%0d_memerr", i), bus.uSeq_MemErr_OUT, tbl[i].err);
        end

        // read stalled for three edges, then acknowledged
        for (int k = 0; k < 3; k++) begin
            cycle(mk(0, 0, 0, 1, 0, 0, 0, 0));
            check("stall_addr", bus.uSeq_CSAddr_OUT, 11'h033);
            check("stall_req", s_req, 1);
            check("stall_dpen", s_dpe, 0);
        end
        cycle(mk(0, 0, 0, 1, 0, 0, 0, 1));
        check("ack_req", s_req, 1);
        check("ack_dpen", s_dpe, 1);
        check("ack_addr", bus.uSeq_CSAddr_OUT, 11'h034);

        // write never acknowledged: trap after 1+16 edges
        for (int k = 0; k < 17; k++) cycle(mk(0, 0, 0, 0, 1, 0, 0, 0));
        check("to_addr", bus.uSeq_CSAddr_OUT, 11'h7FF);
        check("to_err", bus.uSeq_MemErr_OUT, 1);
        check("to_state", bus.uSeq_State_OUT, 3);
        cycle(mk(0, 0, 0, 0, 1, 0, 0, 0));
        check("trap_req", s_req, 0);
        check("trap_dpen", s_dpe, 0);
        check("trap_state", bus.uSeq_State_OUT, 1);
        check("trap_hold", bus.uSeq_CSAddr_OUT, 11'h7FF);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0));
        check("trap_exec", bus.uSeq_CSAddr_OUT, 11'h000);
        check("err_sticky", bus.uSeq_MemErr_OUT, 1);

        // ack arriving on the timeout edge wins
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++) cycle(mk(0, 0, 0, 0, 1, 0, 0, 0));
        check("late_wait", bus.uSeq_State_OUT, 2);
        cycle(mk(0, 0, 0, 0, 1, 0, 0, 1));
        check("late_addr", bus.uSeq_CSAddr_OUT, 11'h001);
        check("late_state", bus.uSeq_State_OUT, 1);
        check("late_err", bus.uSeq_MemErr_OUT, 0);

        // reset with the wait counter at 5
        for (int k = 0; k < 5; k++) cycle(mk(0, 0, 0, 0, 1, 0, 0, 0));
        cycle(mk(1, 0, 0, 0, 1, 0, 0, 0));
        check("rstw_addr", bus.uSeq_CSAddr_OUT, 11'h000);
        check("rstw_state", bus.uSeq_State_OUT, 0);
        cycle(mk(1, 0, 0, 0, 1, 0, 0, 0));
        check("rstw_req", s_req, 0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 17; k++) cycle(mk(0, 0, 0, 0, 1, 0, 0, 0));
        check("pre_rst_err", bus.uSeq_MemErr_OUT, 1);
        cycle(mk(1, 0, 0, 0, 1, 0, 0, 0));
        check("rstt_addr", bus.uSeq_CSAddr_OUT, 11'h000);
        check("rstt_err", bus.uSeq_MemErr_OUT, 0);
        check("rstt_state", bus.uSeq_State_OUT, 0);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // random traffic with varying ack likelihood
        for (int blk = 0; blk < 3; blk++) begin
            thr = (blk == 0) ? 5 : (blk == 1) ? 2 : 0;
            for (int k = 0; k < 150; k++) begin
                v = mk($urandom_range(0, 59) == 0, 3'($urandom_range(0, 7)), 11'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'($urandom), $urandom,
                       $urandom_range(0, 9) < thr);
                cycle(v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
